// File: rtl/sel_pkg.sv
// Shared state encoding and helpers for the selecting-machine controller.
package sel_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_SELECT  = 2'b01,
        S_CONFIRM = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    localparam logic [5:0] CATH_RESET = 6'b111110;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/disp_scan.sv
// Free-running digit scanner: divider plus a rotating active-low one-hot cathode.
module disp_scan
    import sel_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [5:0] digit_cath
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div_q;
    logic [5:0]    cath_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            cath_q <= CATH_RESET;
        end else if (div_q == DW'(SCAN_DIV - 1)) begin
            div_q  <= '0;
            cath_q <= {cath_q[4:0], cath_q[5]};
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

    assign digit_cath = cath_q;

endmodule

// File: rtl/select_ctrl_fsm.sv
// Select/confirm/done sequencing controller with limited selection flags,
// idle timeout abort and display digit scan.
module select_ctrl_fsm
    import sel_pkg::*;
#(
    parameter int unsigned N_CAND   = 6,
    parameter int unsigned MAX_SEL  = 3,
    parameter int unsigned TIMEOUT  = 50_000_000,
    parameter int unsigned HOLD     = 100_000_000,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CAND-1:0] key_pulse,
    input  logic              confirm_pulse,
    input  logic              cancel_pulse,
    output logic [N_CAND-1:0] sel_flags,
    output logic [3:0]        sel_count,
    output logic [1:0]        state,
    output logic              timeout_flag,
    output logic [5:0]        digit_cath
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t            state_q, state_n;
    logic [N_CAND-1:0] flags_q, flags_n;
    logic [3:0]        count_q, count_n;
    logic [TW-1:0]     tcnt_q, tcnt_n;
    logic [HW-1:0]     hcnt_q, hcnt_n;
    logic              tflag_q, tflag_n;

    logic [N_CAND-1:0] kmask;
    logic              key_any;
    logic              tout_hit;
    logic              may_toggle;

    // Isolate the lowest set key bit; higher simultaneous keys are dropped.
    assign kmask      = key_pulse & (~key_pulse + N_CAND'(1));
    assign key_any    = |key_pulse;
    assign tout_hit   = (tcnt_q == TW'(TIMEOUT - 1));
    assign may_toggle = ((flags_q & kmask) != '0) || (count_q < 4'(MAX_SEL));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            flags_q <= '0;
            count_q <= '0;
            tcnt_q  <= '0;
            hcnt_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_n;
            flags_q <= flags_n;
            count_q <= count_n;
            tcnt_q  <= tcnt_n;
            hcnt_q  <= hcnt_n;
            tflag_q <= tflag_n;
        end
    end

    always_comb begin
        state_n = state_q;
        flags_n = flags_q;
        tcnt_n  = tcnt_q;
        hcnt_n  = hcnt_q;
        tflag_n = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cancel_pulse && !confirm_pulse && key_any) begin
                    state_n = S_SELECT;
                    flags_n = flags_q ^ kmask;
                    tcnt_n  = '0;
                end
            end
            S_SELECT: begin
                if (cancel_pulse) begin
                    state_n = S_IDLE;
                    flags_n = '0;
                    tcnt_n  = '0;
                end else if (confirm_pulse) begin
                    tcnt_n = '0;
                    if (count_q != '0) state_n = S_CONFIRM;
                end else if (key_any) begin
                    tcnt_n = '0;
                    if (may_toggle) flags_n = flags_q ^ kmask;
                end else if (tout_hit) begin
                    state_n = S_IDLE;
                    flags_n = '0;
                    tcnt_n  = '0;
                    tflag_n = 1'b1;
                end else begin
                    tcnt_n = tcnt_q + 1'b1;
                end
            end
            S_CONFIRM: begin
                if (cancel_pulse) begin
                    state_n = S_SELECT;
                    tcnt_n  = '0;
                end else if (confirm_pulse) begin
                    state_n = S_DONE;
                    tcnt_n  = '0;
                    hcnt_n  = '0;
                end else if (key_any) begin
                    tcnt_n = '0;
                end else if (tout_hit) begin
                    state_n = S_IDLE;
                    flags_n = '0;
                    tcnt_n  = '0;
                    tflag_n = 1'b1;
                end else begin
                    tcnt_n = tcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (hcnt_q == HW'(HOLD - 1)) begin
                    state_n = S_IDLE;
                    flags_n = '0;
                    hcnt_n  = '0;
                end else begin
                    hcnt_n = hcnt_q + 1'b1;
                end
            end
        endcase
        count_n = popcount8(8'(flags_n));
    end

    disp_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_disp_scan (
        .clk       (clk),
        .rst       (rst),
        .digit_cath(digit_cath)
    );

    assign sel_flags    = flags_q;
    assign sel_count    = count_q;
    assign state        = state_q;
    assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_select_ctrl_fsm.sv
// Scoreboard bench for select_ctrl_fsm: directed pulses push expected outputs,
// a clocked monitor pops and compares one entry after each sampling edge.
module tb_select_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] key_pulse = '0;
    logic       confirm_pulse = 1'b0;
    logic       cancel_pulse = 1'b0;
    logic [5:0] sel_flags;
    logic [3:0] sel_count;
    logic [1:0] state;
    logic       timeout_flag;
    logic [5:0] digit_cath;

    always #5 clk = ~clk;

    select_ctrl_fsm #(
        .N_CAND  (6),
        .MAX_SEL (3),
        .TIMEOUT (20),
        .HOLD    (10),
        .SCAN_DIV(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_pulse    (key_pulse),
        .confirm_pulse(confirm_pulse),
        .cancel_pulse (cancel_pulse),
        .sel_flags    (sel_flags),
        .sel_count    (sel_count),
        .state        (state),
        .timeout_flag (timeout_flag),
        .digit_cath   (digit_cath)
    );

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [5:0] fl;
        logic [3:0] cnt;
        logic       tf;
        logic       chk_cath;
        logic [5:0] cath;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string tag, input string field, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%b required=%b", tag, field, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.tag, "state", 8'(state), 8'(e.st));
                cmp(e.tag, "sel_flags", 8'(sel_flags), 8'(e.fl));
                cmp(e.tag, "sel_count", 8'(sel_count), 8'(e.cnt));
                cmp(e.tag, "timeout_flag", 8'(timeout_flag), 8'(e.tf));
                if (e.chk_cath) cmp(e.tag, "digit_cath", 8'(digit_cath), 8'(e.cath));
            end
        end
    end

    // Drive one cycle of inputs, changed on the falling edge.
    task automatic cyc(input logic [5:0] k, input logic cf, input logic cn, input logic r);
        @(negedge clk);
        key_pulse     = k;
        confirm_pulse = cf;
        cancel_pulse  = cn;
        rst           = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(6'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected outputs after the edge following the most recent cyc().
    task automatic ex(input string tag, input logic [1:0] st, input logic [5:0] fl,
                      input logic [3:0] cnt, input logic tf);
        exp_t e;
        e.tag = tag; e.st = st; e.fl = fl; e.cnt = cnt; e.tf = tf;
        e.chk_cath = 1'b0; e.cath = '0;
        q.push_back(e);
    endtask

    task automatic exc(input string tag, input logic [5:0] cath);
        exp_t e;
        e.tag = tag; e.st = 2'b00; e.fl = '0; e.cnt = '0; e.tf = 1'b0;
        e.chk_cath = 1'b1; e.cath = cath;
        q.push_back(e);
    endtask

    initial begin : stim
        int guard;
        // 1: reset and digit scan
        cyc(6'b0, 1'b0, 1'b0, 1'b1);
        cyc(6'b0, 1'b0, 1'b0, 1'b1);
        exc("reset", 6'b111110);
        for (int n = 1; n <= 24; n++) begin
            cyc(6'b0, 1'b0, 1'b0, 1'b0);
            if (n == 3)  exc("scan3", 6'b111110);
            if (n == 4)  exc("scan4", 6'b111101);
            if (n == 20) exc("scan20", 6'b011111);
            if (n == 24) exc("scan24_wrap", 6'b111110);
        end
        // 2: idle key enters SELECT, same key clears
        cyc(6'b000100, 1'b0, 1'b0, 1'b0); ex("idle_key2", 2'b01, 6'b000100, 4'd1, 1'b0);
        cyc(6'b000100, 1'b0, 1'b0, 1'b0); ex("key2_again", 2'b01, 6'b000000, 4'd0, 1'b0);
        // 3: fill to MAX_SEL, extra set ignored, clear allowed
        cyc(6'b000001, 1'b0, 1'b0, 1'b0); ex("key0", 2'b01, 6'b000001, 4'd1, 1'b0);
        cyc(6'b000010, 1'b0, 1'b0, 1'b0); ex("key1", 2'b01, 6'b000011, 4'd2, 1'b0);
        cyc(6'b000100, 1'b0, 1'b0, 1'b0); ex("key2", 2'b01, 6'b000111, 4'd3, 1'b0);
        cyc(6'b001000, 1'b0, 1'b0, 1'b0); ex("key3_full", 2'b01, 6'b000111, 4'd3, 1'b0);
        cyc(6'b000010, 1'b0, 1'b0, 1'b0); ex("key1_clr", 2'b01, 6'b000101, 4'd2, 1'b0);
        // 4: priority
        cyc(6'b000110, 1'b1, 1'b0, 1'b0); ex("key_confirm", 2'b10, 6'b000101, 4'd2, 1'b0);
        cyc(6'b001000, 1'b0, 1'b0, 1'b0); ex("confirm_key_ign", 2'b10, 6'b000101, 4'd2, 1'b0);
        cyc(6'b000000, 1'b1, 1'b1, 1'b0); ex("confirm_cancel", 2'b01, 6'b000101, 4'd2, 1'b0);
        cyc(6'b000001, 1'b0, 1'b0, 1'b0); ex("clr0", 2'b01, 6'b000100, 4'd1, 1'b0);
        cyc(6'b000100, 1'b0, 1'b0, 1'b0); ex("clr2", 2'b01, 6'b000000, 4'd0, 1'b0);
        cyc(6'b000000, 1'b1, 1'b0, 1'b0); ex("confirm_empty", 2'b01, 6'b000000, 4'd0, 1'b0);
        // 5: confirm, done hold, pulses ignored in DONE
        cyc(6'b000001, 1'b0, 1'b0, 1'b0); ex("t5_key0", 2'b01, 6'b000001, 4'd1, 1'b0);
        cyc(6'b000000, 1'b1, 1'b0, 1'b0); ex("t5_conf", 2'b10, 6'b000001, 4'd1, 1'b0);
        cyc(6'b000000, 1'b1, 1'b0, 1'b0); ex("t5_done", 2'b11, 6'b000001, 4'd1, 1'b0);
        cyc(6'b000010, 1'b0, 1'b0, 1'b0); ex("done_key", 2'b11, 6'b000001, 4'd1, 1'b0);
        cyc(6'b000000, 1'b0, 1'b1, 1'b0); ex("done_cancel", 2'b11, 6'b000001, 4'd1, 1'b0);
        cyc(6'b000000, 1'b1, 1'b0, 1'b0); ex("done_confirm", 2'b11, 6'b000001, 4'd1, 1'b0);
        idle(5);
        cyc(6'b0, 1'b0, 1'b0, 1'b0); ex("hold9", 2'b11, 6'b000001, 4'd1, 1'b0);
        cyc(6'b0, 1'b0, 1'b0, 1'b0); ex("hold10", 2'b00, 6'b000000, 4'd0, 1'b0);
        // 6: timeout restarted by a pulse, then abort
        cyc(6'b000001, 1'b0, 1'b0, 1'b0); ex("t6_key0", 2'b01, 6'b000001, 4'd1, 1'b0);
        idle(15);
        cyc(6'b000010, 1'b0, 1'b0, 1'b0); ex("t6_key1", 2'b01, 6'b000011, 4'd2, 1'b0);
        idle(18);
        cyc(6'b0, 1'b0, 1'b0, 1'b0); ex("tout19", 2'b01, 6'b000011, 4'd2, 1'b0);
        cyc(6'b0, 1'b0, 1'b0, 1'b0); ex("tout20", 2'b00, 6'b000000, 4'd0, 1'b1);
        cyc(6'b0, 1'b0, 1'b0, 1'b0); ex("tout_pulse_end", 2'b00, 6'b000000, 4'd0, 1'b0);
        // reset during CONFIRM
        cyc(6'b000001, 1'b0, 1'b0, 1'b0); ex("r_key0", 2'b01, 6'b000001, 4'd1, 1'b0);
        cyc(6'b000000, 1'b1, 1'b0, 1'b0); ex("r_conf", 2'b10, 6'b000001, 4'd1, 1'b0);
        cyc(6'b000000, 1'b0, 1'b0, 1'b1); exc("rst_confirm", 6'b111110);
        cyc(6'b000000, 1'b0, 1'b0, 1'b0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
